// File: rtl/updown_mod_counter.sv
// updown_mod_counter: up/down counter over 0..limit with load, wrap or saturate at the bounds, and boundary pulses
module updown_mod_counter #(
    parameter int WIDTH    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] q,
    output logic             at_max,
    output logic             at_zero,
    output logic             ovf,
    output logic             unf
);
    logic [WIDTH-1:0] load_clamp, up_nxt, dn_nxt, q_nxt;
    logic             up_bnd, dn_bnd, cnt, ovf_nxt, unf_nxt;
    // q may sit above limit after a limit change, so the up boundary is >=, not ==
    always_comb begin
        load_clamp = (load_val > limit) ? limit : load_val;
        up_bnd     = q >= limit;
        dn_bnd     = q == '0;
        up_nxt     = up_bnd ? (SATURATE ? limit : '0) : q + WIDTH'(1);
        dn_nxt     = dn_bnd ? (SATURATE ? '0 : limit) : q - WIDTH'(1);
        cnt        = !load && en;
        q_nxt      = load ? load_clamp : !en ? q : up_down ? up_nxt : dn_nxt;
        ovf_nxt    = cnt && up_down && up_bnd;
        unf_nxt    = cnt && !up_down && dn_bnd;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            q   <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            q   <= q_nxt;
            ovf <= ovf_nxt;
            unf <= unf_nxt;
        end
    end
    assign at_max  = q == limit;
    assign at_zero = q == '0;
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: directed checks of wrap (4-bit), saturate (4-bit) and wide (8-bit) counters
module tb_updown_mod_counter;
    logic       clk = 1'b0;
    logic       rst, en, up_down, load;
    logic [7:0] load_val, limit;
    logic [3:0] qa, qb;
    logic [7:0] qc;
    logic       mxa, mxb, mxc, za, zb, zc, ova, ovb, ovc, una, unb, unc;
    int         checks = 0;
    int         errors = 0;
    int         dq[4] = '{1, 0, 9, 8};

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4), .SATURATE(1'b0)) dut_a (
        .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val[3:0]), .limit(limit[3:0]), .q(qa),
        .at_max(mxa), .at_zero(za), .ovf(ova), .unf(una));
    updown_mod_counter #(.WIDTH(4), .SATURATE(1'b1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val[3:0]), .limit(limit[3:0]), .q(qb),
        .at_max(mxb), .at_zero(zb), .ovf(ovb), .unf(unb));
    updown_mod_counter #(.WIDTH(8), .SATURATE(1'b0)) dut_c (
        .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val), .limit(limit), .q(qc),
        .at_max(mxc), .at_zero(zc), .ovf(ovc), .unf(unc));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; up_down = 1'b1; load = 1'b1; load_val = 8'd5; limit = 8'd9;
        tick();
        chk("rst_q", qa, 0); chk("rst_ovf", ova, 0); chk("rst_unf", una, 0); chk("rst_zero", za, 1);
        chk("rst_q_sat", qb, 0); chk("rst_q_w8", qc, 0);
        rst = 1'b1; load = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("up_q", qa, i % 10);
            chk("up_ovf", ova, i == 10);
            chk("up_unf", una, 0);
        end
        up_down = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("dn_q", qa, dq[k]);
            chk("dn_unf", una, k == 2);
            chk("dn_ovf", ova, 0);
            chk("dn_zero", za, dq[k] == 0);
            chk("dn_max", mxa, dq[k] == 9);
        end
        en = 1'b0;
        tick();
        chk("hold_q", qa, 8); chk("hold_unf", una, 0);
        load = 1'b1; en = 1'b1; up_down = 1'b1; load_val = 8'd13;
        tick();
        chk("ld_clamp_q", qa, 9); chk("ld_clamp_ovf", ova, 0);
        limit = 8'd10;
        #1 chk("max_track_lo", mxa, 0);
        limit = 8'd9;
        #1 chk("max_track_hi", mxa, 1);
        load_val = 8'd5;
        tick();
        chk("ld_prio_q", qa, 5);
        load_val = 8'd7; up_down = 1'b0;
        tick();
        chk("ld7_q", qa, 7);
        rst = 1'b0;
        tick();
        chk("rst_prio_q", qa, 0); chk("rst_prio_ovf", ova, 0); chk("rst_prio_unf", una, 0);
        rst = 1'b1; load = 1'b0; up_down = 1'b1;
        tick(); chk("resume_q1", qa, 1);
        tick(); chk("resume_q2", qa, 2);
        load = 1'b1; load_val = 8'd9;
        tick(); chk("ld9_q", qa, 9);
        load = 1'b0; rst = 1'b0;
        tick();
        chk("rst_bnd_q", qa, 0); chk("rst_bnd_ovf", ova, 0);
        rst = 1'b1;
        tick();
        chk("post_rst_q", qa, 1); chk("post_rst_ovf", ova, 0);
        limit = 8'd0;
        tick();
        chk("lim0_up_q", qa, 0); chk("lim0_up_ovf", ova, 1);
        tick();
        chk("lim0_up2_ovf", ova, 1);
        up_down = 1'b0;
        tick();
        chk("lim0_dn_q", qa, 0); chk("lim0_dn_unf", una, 1); chk("lim0_dn_ovf", ova, 0);
        limit = 8'd9; load = 1'b1; load_val = 8'd8; up_down = 1'b1;
        tick();
        chk("sat_ld_q", qb, 8);
        load = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("sat_up_q", qb, 9);
            chk("sat_up_ovf", ovb, i >= 2);
        end
        load = 1'b1; load_val = 8'd0; up_down = 1'b0;
        tick();
        chk("sat_ld0_q", qb, 0); chk("sat_ld0_ovf", ovb, 0);
        load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("sat_dn_q", qb, 0);
            chk("sat_dn_unf", unb, 1);
        end
        limit = 8'd255; load = 1'b1; load_val = 8'd200;
        tick();
        chk("w8_ld_q", qc, 200);
        load = 1'b0; limit = 8'd100; up_down = 1'b1;
        tick();
        chk("w8_up_q", qc, 0); chk("w8_up_ovf", ovc, 1);
        limit = 8'd255; load = 1'b1;
        tick();
        load = 1'b0; limit = 8'd100; up_down = 1'b0;
        tick();
        chk("w8_dn_q", qc, 199); chk("w8_dn_unf", unc, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter SATURATE, default 0: 0 = wrap at boundaries, 1 = hold at boundaries.
REQ-003 The block SHALL have port clk  input  1  single clock, all state updated on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port en  input  1  count enable.
REQ-006 The block SHALL have port up_down  input  1  direction: 1 = count up, 0 = count down.
REQ-007 The block SHALL have port load  input  1  synchronous load strobe.
REQ-008 The block SHALL have port load_val  input  WIDTH  value to load.
REQ-009 The block SHALL have port limit  input  WIDTH  upper count bound; the count range is 0..limit inclusive.
REQ-010 The block SHALL have port q  output  WIDTH  registered count value.
REQ-011 The block SHALL have port at_max  output  1  combinational, high when q == limit.
REQ-012 The block SHALL have port at_zero  output  1  combinational, high when q == 0.
REQ-013 The block SHALL have port ovf  output  1  registered, one-cycle pulse on an up-direction boundary event.
REQ-014 The block SHALL have port unf  output  1  registered, one-cycle pulse on a down-direction boundary event.

Function
REQ-015 Priority per rising edge SHALL be: reset, then load, then count; the lower-priority action is ignored in that cycle.
REQ-016 With load=1, q SHALL take min(load_val, limit) on the next edge regardless of en and up_down; ovf and unf SHALL be 0 in that cycle.
REQ-017 With load=0 and en=0, q SHALL hold; ovf and unf SHALL be 0 in that cycle.
REQ-018 With load=0, en=1, up_down=1 and q < limit, q SHALL increment by 1 (latency 1 clock).
REQ-019 With load=0, en=1, up_down=1 and q >= limit (up boundary), ovf SHALL pulse high for one cycle; q SHALL become 0 if SATURATE=0, or limit if SATURATE=1.
REQ-020 With load=0, en=1, up_down=0 and q > 0, q SHALL decrement by 1, including when q > limit after a limit change.
REQ-021 With load=0, en=1, up_down=0 and q == 0 (down boundary), unf SHALL pulse high for one cycle; q SHALL become limit if SATURATE=0, or hold at 0 if SATURATE=1.
REQ-022 With limit == 0, every enabled count SHALL be a boundary event; q SHALL stay 0 and ovf or unf SHALL pulse per direction.
REQ-023 All arithmetic SHALL be WIDTH bits unsigned; no intermediate result may exceed limit or wrap modulo 2^WIDTH except as defined in REQ-019 and REQ-021.
REQ-024 ovf and unf SHALL never be high in the same cycle, and each SHALL be high for no more than one cycle per boundary event.
REQ-025 Continuous counting in saturate mode at a boundary SHALL pulse ovf (or unf) on every enabled edge while the boundary persists.
REQ-026 Changes on limit SHALL take effect on the next edge; at_max SHALL track limit combinationally.

Reset
REQ-027 When rst=0 at a rising edge, q SHALL become 0, and ovf and unf SHALL become 0, overriding load and en.
REQ-028 Asserting reset mid-count SHALL discard any pending boundary pulse; counting SHALL resume from 0 on the first edge with rst=1.
REQ-029 Before the first reset edge, output values are undefined; the bench SHALL apply reset for at least 1 edge before checking.

Verification
REQ-030 WIDTH=4, SATURATE=0, limit=9: reset, en=1, up_down=1 for 12 edges -> q = 1..9, 0, 1, 2; ovf high only on the edge q 9->0.
REQ-031 WIDTH=4, SATURATE=0, limit=9: from q=2, up_down=0 for 4 edges -> q = 1, 0, 9, 8; unf high only on the edge q 0->9; at_zero high while q=0.
REQ-032 WIDTH=4, SATURATE=1, limit=9: load_val=8, then count up 3 edges -> q = 9, 9, 9; ovf high on the 2nd and 3rd edges; then down from 0 -> q holds 0 with unf pulsing.
REQ-033 WIDTH=4, limit=9: load=1, en=1, load_val=13 -> q = 9 (clamped), no ovf; load_val=5 with up_down=1 -> q = 5, not 6.
REQ-034 WIDTH=4: q=7, rst=0 with load=1 and en=1 on the same edge -> q = 0, ovf = unf = 0; rst=1 then 2 up edges -> q = 1, 2.
REQ-035 WIDTH=8, SATURATE=0: q=200, limit changed to 100, up 1 edge -> q = 0 with ovf; separately q=200, limit=100, down 1 edge -> q = 199, no unf.
